farm_pmem_resp: RTL and testbench

Program-memory responder for the farm core: the memory-side end of the instruction-fetch interface driven by the fetch unit's address generator. It accepts one word fetch at a time, applies a parameterised number of wait states, and returns the instruction word with a valid/ready handshake. A word-write load port fills the array at boot, so the array is loaded in hardware rather than through simulator preload. It sits inside the program-memory interface, between the fetch stage and the instruction storage.

---
 rtl/farm_pkg.sv | 7 +
 rtl/farm_pmem_resp_if.sv | 15 +
 rtl/farm_pmem_ram.sv | 31 +++
 rtl/farm_pmem_resp.sv | 116 +++++++++++
 tb/tb_farm_pmem_resp.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/farm_pkg.sv
// Shared types and constants for the farm core.
package farm_pkg;
  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} pmem_state_t;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam int          WORD_BYTES = 4;
endpackage

// File: rtl/farm_pmem_resp_if.sv
// Instruction-fetch request/response bundle between fetch unit and program memory.
interface farm_pmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (output req_valid, req_addr, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave  (input  req_valid, req_addr, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/farm_pmem_ram.sv
// Single-port program RAM, DEPTH x 32, write port plus registered read.
module farm_pmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  // No reset: contents survive a core reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

  task automatic dump(input int first, input int last, output logic [31:0] words [DEPTH]);
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = (i >= first && i <= last) ? mem[i] : '0;
    end
  endtask
endmodule

// File: rtl/farm_pmem_resp.sv
// Program-memory responder: one fetch at a time, WAIT_CYC wait states, boot load port.
module farm_pmem_resp
  import farm_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          WAIT_CYC = 1,
  parameter logic [31:0] NOP_WORD = RV_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  farm_pmem_resp_if.slave   fetch,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready
);
  localparam int         OFFS_W    = $clog2(WORD_BYTES);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  pmem_state_t       state_reg, state_next;
  logic [3:0]        wait_reg, wait_next;
  logic              err_reg;
  logic              rsp_err_reg;
  logic [31:0]       rsp_data_reg;
  logic              req_ready;
  logic              accept;
  logic              addr_err;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       ram_rdata;

  assign word_idx = fetch.req_addr[ADDR_W+OFFS_W-1:OFFS_W];
  assign addr_err = (|fetch.req_addr[OFFS_W-1:0]) || (|fetch.req_addr[31:ADDR_W+OFFS_W]);

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    req_ready  = 1'b0;
    ld_ready   = 1'b0;
    accept     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = ld_valid ? ld_addr : word_idx;
    unique case (state_reg)
      IDLE: begin
        // Load port wins; a fetch waits for the next IDLE cycle.
        ld_ready  = rst_n;
        req_ready = rst_n && !ld_valid;
        if (ld_valid && rst_n) begin
          ram_we = 1'b1;
        end else if (fetch.req_valid && req_ready) begin
          accept     = 1'b1;
          ram_re     = !addr_err;
          state_next = READ;
        end
      end
      READ: begin
        if (WAIT_CYC > 0) begin
          state_next = WAIT;
          wait_next  = WAIT_INIT;
        end else begin
          state_next = RESP;
        end
      end
      WAIT: begin
        if (wait_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          wait_next = wait_reg - 4'd1;
        end
      end
      RESP: begin
        if (fetch.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_reg     <= '0;
      err_reg      <= 1'b0;
      rsp_err_reg  <= 1'b0;
      rsp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (accept) begin
        err_reg <= addr_err;
      end
      // RAM output is held since the read, so capture it once on entry to RESP.
      if (state_next == RESP && state_reg != RESP) begin
        rsp_data_reg <= err_reg ? NOP_WORD : ram_rdata;
        rsp_err_reg  <= err_reg;
      end
    end
  end

  assign fetch.req_ready = req_ready;
  assign fetch.rsp_valid = (state_reg == RESP);
  assign fetch.rsp_data  = rsp_data_reg;
  assign fetch.rsp_err   = rsp_err_reg;

  farm_pmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_farm_pmem_resp.sv
// Randomized self-checking bench for farm_pmem_resp against a word-array reference model.
module tb_farm_pmem_resp;
  import farm_pkg::*;

  localparam int AW    = 8;
  localparam int W1    = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready, ld_ready2;

  farm_pmem_resp_if ifc ();
  farm_pmem_resp_if ifc2 ();

  farm_pmem_resp #(.ADDR_W(AW), .WAIT_CYC(W1), .NOP_WORD(RV_NOP)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(ifc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready)
  );

  farm_pmem_resp #(.ADDR_W(AW), .WAIT_CYC(0), .NOP_WORD(RV_NOP)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch(ifc2),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    return (a % WORD_BYTES != 0) || (a / (WORD_BYTES * DEPTH) != 0);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_err(a) ? RV_NOP : model[(a / WORD_BYTES) % DEPTH];
  endfunction

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    #1;
    chk("ld_ready", 32'(ld_ready), 32'd1);
    chk("ld_ready_w0", 32'(ld_ready2), 32'd1);
    model[a] = d;
    @(negedge clk);
    ld_valid = 1'b0;
    $display("load  addr=%0d data=%h", a, d);
  endtask

  // Latency counts cycles from the first cycle req_valid is presented
  // to the first cycle rsp_valid is high.
  task automatic fetch(input logic [31:0] addr, input int stall, input bit collide,
                       input logic [AW-1:0] caddr, input logic [31:0] cdata);
    int t0, n, lat;
    bit acc;
    logic [31:0] exp_d;
    logic exp_e;
    t0 = cyc;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = addr;
    ifc.rsp_ready = 1'b0;
    if (collide) begin
      ld_valid = 1'b1;
      ld_addr  = caddr;
      ld_data  = cdata;
    end
    #1;
    if (collide) begin
      chk("col_req_ready", 32'(ifc.req_ready), 32'd0);
      chk("col_ld_ready", 32'(ld_ready), 32'd1);
      model[caddr] = cdata;
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
    end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 8) begin
      if (ifc.req_ready) acc = 1'b1;
      @(negedge clk);
      n++;
    end
    ifc.req_valid = 1'b0;
    if (!acc) chk("acc_timeout", 32'd0, 32'd1);
    exp_d = exp_word(addr);
    exp_e = exp_err(addr);
    n = 0;
    while (!ifc.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0;
    chk("rsp_valid", 32'(ifc.rsp_valid), 32'd1);
    chk("rsp_data", ifc.rsp_data, exp_d);
    chk("rsp_err", 32'(ifc.rsp_err), 32'(exp_e));
    chk("latency", 32'(lat), 32'(2 + W1 + int'(collide)));
    $display("fetch addr=%h data=%h err=%0d lat=%0d stall=%0d", addr, ifc.rsp_data, ifc.rsp_err, lat, stall);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      ifc.req_valid = 1'($urandom_range(0, 1));
      ifc.req_addr  = $urandom;
      #1;
      chk("stall_valid", 32'(ifc.rsp_valid), 32'd1);
      chk("stall_data", ifc.rsp_data, exp_d);
      chk("stall_req_ready", 32'(ifc.req_ready), 32'd0);
      chk("stall_ld_ready", 32'(ld_ready), 32'd0);
    end
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(ifc.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog [4];
    logic [31:0] pa;
    logic [31:0] expq [$];
    int got, last;

    prog[0] = 32'h00500093; prog[1] = 32'h00a00113;
    prog[2] = 32'h002081b3; prog[3] = 32'h00000013;
    ifc.req_valid = 1'b0;  ifc.req_addr = '0;  ifc.rsp_ready = 1'b0;
    ifc2.req_valid = 1'b0; ifc2.req_addr = '0; ifc2.rsp_ready = 1'b0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rsp_data", ifc.rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
    chk("idle_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("idle_ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);

    // Boot image, then in-order fetches
    for (int i = 0; i < 4; i++) load(AW'(i), prog[i]);
    for (int i = 4; i < 16; i++) load(AW'(i), $urandom);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 0, 1'b0, '0, '0);

    // Misaligned and out-of-range
    fetch(32'h6, 0, 1'b0, '0, '0);
    fetch(32'h400, 0, 1'b0, '0, '0);

    // Load and fetch in the same IDLE cycle
    fetch(32'h8, 0, 1'b1, AW'(2), 32'hdeadbeef);

    // Response stall with ignored request pulses
    fetch(32'h4, 5, 1'b0, '0, '0);

    // Reset during WAIT
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 32'h8;
    #1;
    chk("r_acc_ready", 32'(ifc.req_ready), 32'd1);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r_req_ready", 32'(ifc.req_ready), 32'd0);
    chk("r_ld_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    chk("r_valid", 32'(ifc.rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("r_idle", 32'(ifc.req_ready), 32'd1);
    $display("reset during WAIT");
    fetch(32'h8, 0, 1'b0, '0, '0);
    fetch(32'h0, 0, 1'b0, '0, '0);

    // Zero-wait instance: back-to-back fetches, one response every 3 cycles
    pa = '0;
    got = 0;
    last = 0;
    ifc2.req_valid = 1'b1;
    ifc2.req_addr  = pa;
    ifc2.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      #1;
      if (ifc2.rsp_valid) begin
        if (expq.size() == 0) begin
          chk("p_spurious", 32'd1, 32'd0);
        end else begin
          chk("p_data", ifc2.rsp_data, expq.pop_front());
        end
        if (got > 0) chk("p_period", 32'(cyc - last), 32'd3);
        $display("fetch0 data=%h cyc=%0d", ifc2.rsp_data, cyc);
        last = cyc;
        got++;
      end
      if (ifc2.req_valid && ifc2.req_ready) begin
        expq.push_back(exp_word(pa));
        pa = pa + 32'd4;
      end
      @(negedge clk);
      ifc2.req_addr = pa;
    end
    ifc2.req_valid = 1'b0;
    ifc2.rsp_ready = 1'b0;
    chk("p_count", 32'(got), 32'd6);
    @(negedge clk);

    // Random mix of loads and fetches
    for (int it = 0; it < 30; it++) begin
      int kind, cls, w;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      w = $urandom_range(0, 15);
      if (kind == 0) begin
        load(AW'(w), $urandom);
      end else begin
        cls = $urandom_range(0, 5);
        a = 32'(w * WORD_BYTES);
        if (cls == 0) a = a + 32'($urandom_range(1, 3));
        else if (cls == 1) a = a | (32'd1 << $urandom_range(10, 31));
        fetch(a, $urandom_range(0, 2), 1'b0, '0, '0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
